instr_fetch_ctrl: RTL and testbench

INSTR_FETCH_CTRL -- requirements
Module: instr_fetch_ctrl

---
 rtl/instr_fetch_ctrl.sv | 238 +++++++++++++++++++++++
 tb/tb_instr_fetch_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: walks a combinational 64-bit instruction store, merges
// two-slot lddw immediates and hands one instruction at a time to decode.
// Optional feature macro: FETCH_PERF_CNT_EN (retired-instruction counter on instr_count).
module instr_fetch_ctrl #(
    parameter int unsigned PROG_LEN = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] entry_pc,
    output logic [31:0] rom_addr,
    input  logic [63:0] rom_instr,
    output logic [63:0] instr_out,
    output logic [31:0] imm_hi,
    output logic [31:0] pc_out,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        busy,
    output logic        halt,
    output logic        fault,
    output logic [31:0] instr_count
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_FETCH2 = 3'd2,
        S_HOLD   = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    localparam logic [32:0] PROG_LEN_EXT = 33'(PROG_LEN);
    localparam logic [7:0]  OP_LDDW      = 8'h18;
    localparam logic [7:0]  OP_EXIT      = 8'h95;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [63:0] instr_q, instr_d;
    logic [31:0] imm_q, imm_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic        halt_q, halt_d;
    logic        fault_q, fault_d;

    logic        fetch_oob_s;
    logic        fetch2_oob_s;
    logic        start_ok_s;
    logic        xfer_s;
    logic        held_lddw_s;
    logic        held_exit_s;
    logic [31:0] step_s;

    // Decode helpers; bounds are checked in 33 bits so pc+1 cannot wrap into range.
    assign fetch_oob_s  = ({1'b0, pc_q} >= PROG_LEN_EXT);
    assign fetch2_oob_s = (({1'b0, pc_q} + 33'd1) >= PROG_LEN_EXT);
    assign start_ok_s   = start && ((state_q == S_IDLE) || (state_q == S_HALT));
    assign xfer_s       = (state_q == S_HOLD) && instr_ready;
    assign held_lddw_s  = (instr_q[7:0] == OP_LDDW);
    assign held_exit_s  = (instr_q[7:0] == OP_EXIT);
    assign step_s       = held_lddw_s ? 32'd2 : 32'd1;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; redirect outranks fault and exit in every running state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_HALT: begin
                if (start_ok_s) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = state_q;
                end
            end
            S_FETCH: begin
                if (redirect) begin
                    state_d = S_FETCH;
                end else if (fetch_oob_s) begin
                    state_d = S_HALT;
                end else if (rom_instr[7:0] == OP_LDDW) begin
                    state_d = S_FETCH2;
                end else begin
                    state_d = S_HOLD;
                end
            end
            S_FETCH2: begin
                if (redirect) begin
                    state_d = S_FETCH;
                end else if (fetch2_oob_s) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    state_d = S_FETCH;
                end else if (xfer_s) begin
                    state_d = held_exit_s ? S_HALT : S_FETCH;
                end else begin
                    state_d = S_HOLD;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from the state register.
    always_comb begin
        instr_valid = (state_q == S_HOLD);
        busy        = (state_q == S_FETCH) || (state_q == S_FETCH2) || (state_q == S_HOLD);
        if (state_q == S_FETCH2) begin
            rom_addr = pc_q + 32'd1;
        end else begin
            rom_addr = pc_q;
        end
    end

    // Datapath next values: pc, captured instruction, immediate and status flags.
    always_comb begin
        pc_d     = pc_q;
        instr_d  = instr_q;
        imm_d    = imm_q;
        pc_out_d = pc_out_q;
        halt_d   = halt_q;
        fault_d  = fault_q;
        case (state_q)
            S_IDLE, S_HALT: begin
                if (start_ok_s) begin
                    pc_d    = entry_pc;
                    halt_d  = 1'b0;
                    fault_d = 1'b0;
                end else begin
                    pc_d = pc_q;
                end
            end
            S_FETCH: begin
                if (redirect) begin
                    pc_d = redirect_pc;
                end else if (fetch_oob_s) begin
                    fault_d = 1'b1;
                end else begin
                    instr_d  = rom_instr;
                    pc_out_d = pc_q;
                    imm_d    = 32'd0;
                end
            end
            S_FETCH2: begin
                if (redirect) begin
                    pc_d = redirect_pc;
                end else if (fetch2_oob_s) begin
                    fault_d = 1'b1;
                end else begin
                    imm_d = rom_instr[63:32];
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    pc_d = redirect_pc;
                end else if (xfer_s) begin
                    if (held_exit_s) begin
                        halt_d = 1'b1;
                    end else begin
                        pc_d = pc_q + step_s;
                    end
                end else begin
                    pc_d = pc_q;
                end
            end
            default: begin
                pc_d = pc_q;
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= 32'd0;
            instr_q  <= 64'd0;
            imm_q    <= 32'd0;
            pc_out_q <= 32'd0;
            halt_q   <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            imm_q    <= imm_d;
            pc_out_q <= pc_out_d;
            halt_q   <= halt_d;
            fault_q  <= fault_d;
        end
    end

    assign instr_out = instr_q;
    assign imm_hi    = imm_q;
    assign pc_out    = pc_out_q;
    assign halt      = halt_q;
    assign fault     = fault_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] cnt_q, cnt_d;

    // Saturating retire counter; a transfer that coincides with redirect still counts.
    always_comb begin
        cnt_d = cnt_q;
        if (start_ok_s) begin
            cnt_d = 32'd0;
        end else if (xfer_s && (cnt_q != 32'hFFFF_FFFF)) begin
            cnt_d = cnt_q + 32'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 32'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign instr_count = cnt_q;
`else
    assign instr_count = 32'd0;
`endif

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Self-checking bench for instr_fetch_ctrl: transaction-level reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_instr_fetch_ctrl;

    localparam int unsigned PL = 16;
`ifdef FETCH_PERF_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] entry_pc;
    logic [31:0] rom_addr;
    logic [63:0] rom_instr;
    logic [63:0] instr_out;
    logic [31:0] imm_hi;
    logic [31:0] pc_out;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        busy;
    logic        halt;
    logic        fault;
    logic [31:0] instr_count;

    logic [63:0] mem [0:31];
    int total = 0;
    int bad = 0;

    assign rom_instr = (rom_addr < 32'd32) ? mem[rom_addr[4:0]] : 64'hA5A5_A5A5_5A5A_5A95;

    instr_fetch_ctrl #(.PROG_LEN(PL)) dut (
        .clk(clk), .rst(rst), .start(start), .entry_pc(entry_pc),
        .rom_addr(rom_addr), .rom_instr(rom_instr), .instr_out(instr_out),
        .imm_hi(imm_hi), .pc_out(pc_out), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .redirect(redirect), .redirect_pc(redirect_pc),
        .busy(busy), .halt(halt), .fault(fault), .instr_count(instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a fetch is a countdown to either presentation or fault.
    logic        m_busy, m_present, m_halt, m_fault, m_will_fault;
    int          m_left;
    int          m_retired;
    logic [31:0] m_pc, m_step, m_cnt;
    logic [63:0] pend_instr, exp_instr;
    logic [31:0] pend_imm, exp_imm;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic begin_fetch(input logic [31:0] p);
        logic [63:0] w;
        logic [63:0] w2;
        m_busy = 1'b1;
        m_present = 1'b0;
        m_pc = p;
        m_step = 32'd0;
        if ({1'b0, p} >= 33'(PL)) begin
            m_left = 1;
            m_will_fault = 1'b1;
        end else begin
            w = mem[p[4:0]];
            pend_instr = w;
            if (w[7:0] == 8'h18) begin
                m_left = 2;
                if (({1'b0, p} + 33'd1) >= 33'(PL)) begin
                    m_will_fault = 1'b1;
                end else begin
                    m_will_fault = 1'b0;
                    w2 = mem[p[4:0] + 5'd1];
                    pend_imm = w2[63:32];
                end
            end else begin
                m_left = 1;
                m_will_fault = 1'b0;
                pend_imm = 32'd0;
            end
        end
    endtask

    task automatic model_step();
        logic xfer;
        if (rst) begin
            m_busy = 1'b0; m_present = 1'b0; m_halt = 1'b0; m_fault = 1'b0;
            m_cnt = 32'd0; m_pc = 32'd0; m_step = 32'd0; m_retired = 0;
        end else if (!m_busy) begin
            if (start) begin
                m_halt = 1'b0; m_fault = 1'b0; m_cnt = 32'd0; m_retired = 0;
                begin_fetch(entry_pc);
            end
        end else begin
            xfer = m_present && instr_ready;
            if (xfer) begin
                if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
                m_retired++;
            end
            if (redirect) begin
                begin_fetch(redirect_pc);
            end else if (m_present) begin
                if (xfer) begin
                    if (exp_instr[7:0] == 8'h95) begin
                        m_busy = 1'b0; m_present = 1'b0; m_halt = 1'b1;
                    end else begin
                        begin_fetch(m_pc + ((exp_instr[7:0] == 8'h18) ? 32'd2 : 32'd1));
                    end
                end
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_step = 32'd0;
                    if (m_will_fault) begin
                        m_busy = 1'b0; m_fault = 1'b1;
                    end else begin
                        m_present = 1'b1;
                        exp_instr = pend_instr;
                        exp_imm = pend_imm;
                    end
                end else begin
                    m_step = m_step + 32'd1;
                end
            end
        end
    endtask

    task automatic compare();
        chk("busy", {63'd0, busy}, {63'd0, m_busy});
        chk("instr_valid", {63'd0, instr_valid}, {63'd0, m_present});
        chk("halt", {63'd0, halt}, {63'd0, m_halt});
        chk("fault", {63'd0, fault}, {63'd0, m_fault});
        chk("instr_count", {32'd0, instr_count}, {32'd0, (CNT_EN ? m_cnt : 32'd0)});
        if (m_present) begin
            chk("instr_out", instr_out, exp_instr);
            chk("imm_hi", {32'd0, imm_hi}, {32'd0, exp_imm});
            chk("pc_out", {32'd0, pc_out}, {32'd0, m_pc});
        end else if (m_busy) begin
            chk("rom_addr", {32'd0, rom_addr}, {32'd0, m_pc + m_step});
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        compare();
    endtask

    task automatic quiet_in();
        rst = 1'b0; start = 1'b0; entry_pc = 32'd0;
        instr_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
    endtask

    task automatic wait_valid(input int budget, output int n);
        n = 0;
        while (!instr_valid && n < budget) begin
            cyc();
            n++;
        end
        if (!instr_valid) chk("wait_valid_timeout", 64'd0, 64'd1);
    endtask

    task automatic run_until_idle(input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            cyc();
            n++;
        end
        if (busy) chk("run_idle_timeout", 64'd1, 64'd0);
    endtask

    task automatic load_prog();
        for (int i = 0; i < 32; i++) mem[i] = 64'h0000_0000_0000_0007;
        mem[0] = 64'h0000_0002_0000_0118;
        mem[1] = 64'h0000_0005_0000_0000;
        mem[2] = 64'h0000_0000_0000_0095;
    endtask

    task automatic rand_mem();
        int r;
        logic [63:0] w;
        for (int i = 0; i < 32; i++) begin
            r = $urandom_range(0, 99);
            w = {$urandom, $urandom};
            if (r < 20) w[7:0] = 8'h18;
            else if (r < 28) w[7:0] = 8'h95;
            else w[7:0] = 8'h07;
            mem[i] = w;
        end
    endtask

    initial begin
        int n;
        bit seen_valid;
        logic [63:0] snap;
        quiet_in();
        load_prog();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        chk("rst_instr_out", instr_out, 64'd0);
        chk("rst_pc_out", {32'd0, pc_out}, 64'd0);
        chk("rst_rom_addr", {32'd0, rom_addr}, 64'd0);
        chk("rst_imm_hi", {32'd0, imm_hi}, 64'd0);

        // lddw then exit, ready held high
        start = 1'b1; entry_pc = 32'd0; instr_ready = 1'b1;
        cyc();
        start = 1'b0;
        wait_valid(10, n);
        chk("lddw_latency", n, 64'd2);
        chk("lddw_instr", instr_out, 64'h0000_0002_0000_0118);
        chk("lddw_imm", {32'd0, imm_hi}, 64'h5);
        chk("lddw_pc", {32'd0, pc_out}, 64'd0);
        cyc();
        wait_valid(10, n);
        chk("exit_latency", n, 64'd1);
        chk("exit_pc", {32'd0, pc_out}, 64'd2);
        chk("exit_imm", {32'd0, imm_hi}, 64'd0);
        cyc();
        chk("exit_halt", {63'd0, halt}, 64'd1);
        chk("exit_count", {32'd0, instr_count}, {32'd0, (CNT_EN ? 32'd2 : 32'd0)});

        // stall in HOLD for five cycles
        start = 1'b1; instr_ready = 1'b0;
        cyc();
        start = 1'b0;
        wait_valid(10, n);
        snap = instr_out;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("stall_valid", {63'd0, instr_valid}, 64'd1);
            chk("stall_pc", {32'd0, pc_out}, 64'd0);
            chk("stall_instr", instr_out, 64'h0000_0002_0000_0118);
        end
        instr_ready = 1'b1;
        run_until_idle(20);

        // redirect from an un-transferred HOLD
        mem[8] = 64'h0000_0000_0000_0095;
        start = 1'b1; instr_ready = 1'b0;
        cyc();
        start = 1'b0;
        wait_valid(10, n);
        redirect = 1'b1; redirect_pc = 32'd7;
        cyc();
        redirect = 1'b0;
        chk("redir_drop", {63'd0, instr_valid}, 64'd0);
        instr_ready = 1'b1;
        wait_valid(10, n);
        chk("redir_pc", {32'd0, pc_out}, 64'd7);
        chk("redir_none_retired", m_retired, 64'd0);
        run_until_idle(20);

        // lddw in the last slot faults without presenting
        mem[PL-1] = 64'h0000_0000_0000_0018;
        start = 1'b1; entry_pc = PL - 1;
        cyc();
        start = 1'b0;
        seen_valid = 1'b0;
        n = 0;
        while (busy && n < 10) begin
            seen_valid |= instr_valid;
            cyc();
            n++;
        end
        chk("oob2_fault", {63'd0, fault}, 64'd1);
        chk("oob2_halt", {63'd0, halt}, 64'd0);
        chk("oob2_novalid", {63'd0, seen_valid}, 64'd0);
        start = 1'b1; entry_pc = 32'd20;
        cyc();
        start = 1'b0;
        cyc();
        chk("oob_fault", {63'd0, fault}, 64'd1);

        // reset during the second lddw slot
        start = 1'b1; entry_pc = 32'd0;
        cyc();
        start = 1'b0;
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_instr", instr_out, 64'd0);
        chk("midrst_pc_out", {32'd0, pc_out}, 64'd0);
        chk("midrst_rom_addr", {32'd0, rom_addr}, 64'd0);
        start = 1'b1; entry_pc = 32'd2;
        cyc();
        start = 1'b0;
        wait_valid(10, n);
        chk("post_rst_pc", {32'd0, pc_out}, 64'd2);
        cyc();
        chk("post_rst_halt", {63'd0, halt}, 64'd1);

        // redirect beats exit in the same cycle
        start = 1'b1; entry_pc = 32'd2; instr_ready = 1'b0;
        cyc();
        start = 1'b0;
        wait_valid(10, n);
        instr_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'd0;
        cyc();
        redirect = 1'b0; instr_ready = 1'b0;
        chk("redir_exit_halt", {63'd0, halt}, 64'd0);
        chk("redir_exit_busy", {63'd0, busy}, 64'd1);
        wait_valid(10, n);
        chk("redir_exit_pc", {32'd0, pc_out}, 64'd0);
        instr_ready = 1'b1;
        run_until_idle(30);

        // randomized traffic
        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            if (!m_busy && $urandom_range(0, 3) == 0) begin
                rand_mem();
                start = 1'b1;
                entry_pc = $urandom_range(0, 17);
            end else begin
                start = ($urandom_range(0, 19) == 0);
                entry_pc = $urandom_range(0, 17);
            end
            instr_ready = ($urandom_range(0, 9) < 7);
            redirect = ($urandom_range(0, 19) == 0);
            redirect_pc = $urandom_range(0, 19);
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
